// File: rtl/mio_tx_arb_pkg.sv
// Shared mio parameter header: default sizing for the mio transmit datapath blocks.
package mio_tx_arb_pkg;

   localparam int MIO_N     = 2;
   localparam int MIO_PW    = 104;
   localparam int MIO_BURST = 4;

   // Index width that stays legal when only one requester exists.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mio_tx_arb_if.sv
// Requester-side and mio-side signals of the transmit arbiter, plus owner/cnt debug taps.
interface mio_tx_arb_if
   import mio_tx_arb_pkg::*;
#(
   parameter int N     = MIO_N,
   parameter int PW    = MIO_PW,
   parameter int BURST = MIO_BURST
);

   localparam int OW = idx_w(N);
   localparam int CW = $clog2(BURST + 1);

   // Handshake: a requester holds access_in[i]/packet_in[i] steady while wait_out[i]
   // is high; a packet moves when access_in[i]=1 and wait_out[i]=0 at a rising edge.
   // Toward mio, the registered access_out/packet_out hold while wait_in is high.
   logic [N-1:0]    access_in;
   logic [N*PW-1:0] packet_in;
   logic [N-1:0]    wait_out;
   logic            access_out;
   logic [PW-1:0]   packet_out;
   logic            wait_in;
   logic [N-1:0]    grant;
   logic [OW-1:0]   dbg_owner;
   logic [CW-1:0]   dbg_cnt;

   modport slave (
      input  access_in, packet_in, wait_in,
      output wait_out, access_out, packet_out, grant, dbg_owner, dbg_cnt
   );

   modport master (
      output access_in, packet_in, wait_in,
      input  wait_out, access_out, packet_out, grant, dbg_owner, dbg_cnt
   );

endinterface

// File: rtl/mio_rrarb.sv
// Combinational rotating priority pick: first requester after the owner wins,
// wrapping so that the owner itself is the last candidate.
module mio_rrarb #(
   parameter int N  = 2,
   parameter int OW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [OW-1:0] owner_i,
   output logic [N-1:0]  win_o
);

   logic found;

   always_comb begin
      win_o = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (i > int'(owner_i))) begin
            win_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (i <= int'(owner_i))) begin
            win_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mio_tx_arb.sv
// N-to-1 burst-limited round-robin arbiter feeding one registered packet per cycle
// into the mio transmit path.
module mio_tx_arb
   import mio_tx_arb_pkg::*;
#(
   parameter int N     = MIO_N,
   parameter int PW    = MIO_PW,
   parameter int BURST = MIO_BURST
) (
   input logic        clk,
   input logic        reset,
   mio_tx_arb_if.slave bus
);

   localparam int OW = idx_w(N);
   localparam int CW = $clog2(BURST + 1);

   logic [OW-1:0] owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          access_q, access_d;
   logic [PW-1:0] packet_q, packet_d;

   logic          ready;
   logic          any_req;
   logic          keep;
   logic [N-1:0]  rr_win;
   logic [N-1:0]  win;
   logic [N-1:0]  grant_c;
   logic [OW-1:0] win_idx;
   logic [PW-1:0] pkt_sel;

   mio_rrarb #(
      .N  (N),
      .OW (OW)
   ) u_rrarb (
      .req_i   (bus.access_in),
      .owner_i (owner_q),
      .win_o   (rr_win)
   );

   always_comb begin
      ready   = ~access_q | ~bus.wait_in;
      any_req = |bus.access_in;
      // cnt of zero means no burst is in progress (post-reset), so rotation decides.
      keep    = (cnt_q != '0) && (cnt_q < CW'(BURST)) && bus.access_in[owner_q];
      win     = keep ? (N'(1) << owner_q) : rr_win;
      win_idx = '0;
      pkt_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (win[i]) begin
            win_idx = OW'(i);
            pkt_sel = bus.packet_in[i*PW +: PW];
         end
      end
      grant_c = (ready && !reset) ? win : '0;

      owner_d  = owner_q;
      cnt_d    = cnt_q;
      access_d = access_q;
      packet_d = packet_q;
      if (ready) begin
         if (any_req) begin
            access_d = 1'b1;
            packet_d = pkt_sel;
            if (win_idx == owner_q) begin
               cnt_d = (cnt_q < CW'(BURST)) ? cnt_q + CW'(1) : CW'(1);
            end else begin
               owner_d = win_idx;
               cnt_d   = CW'(1);
            end
         end else begin
            access_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= OW'(N - 1);
         cnt_q    <= '0;
         access_q <= 1'b0;
         packet_q <= '0;
      end else begin
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         access_q <= access_d;
         packet_q <= packet_d;
      end
   end

   assign bus.grant      = grant_c;
   assign bus.wait_out   = reset ? '1 : (bus.access_in & ~grant_c);
   assign bus.access_out = access_q;
   assign bus.packet_out = packet_q;
   assign bus.dbg_owner  = owner_q;
   assign bus.dbg_cnt    = cnt_q;

endmodule
